// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencer between the execute stage and the shared multi-cycle
// multiply/divide engine.
//
// Operation:
//   - Accepts a level-held request from the execute stage and latches the
//     operation into the eng_* registers.
//   - Answers the request without the engine when the tuple matches the last
//     engine result, or when it is a divide-by-zero or signed-overflow divide.
//   - Otherwise pulses eng_start_o and waits for eng_done_i.
//   - Returns the result with a one-cycle done_o pulse.
//   - A flush while the engine is busy cancels it with a one-cycle
//     eng_abort_o pulse.
//
// Ports:
//   clk, rst            core clock, asynchronous active-low reset
//   req_i               execute-stage request, held until done_o
//   mul_or_div_i        0 = MUL, 1 = DIV
//   a_i, b_i            operands
//   a_unsigned_i,
//   b_unsigned_i        operand signedness (1 = unsigned)
//   flush_i             kill of the in-flight instruction
//   done_o              one-cycle result-valid pulse
//   result_o            MUL: full product, DIV: {quotient, remainder}
//   stall_o             pipeline hold (combinational)
//   eng_start_o         one-cycle engine start pulse
//   eng_abort_o         one-cycle engine cancel pulse
//   eng_*_o             latched operation presented to the engine
//   eng_done_i          engine completion pulse
//   eng_result_i        engine result, same format as result_o
module muldiv_ctrl #(
    parameter int unsigned DATA_W     = 32,
    parameter bit          CACHE_EN   = 1'b1,
    parameter bit          SPECIAL_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic                  mul_or_div_i,
    input  logic [DATA_W-1:0]     a_i,
    input  logic [DATA_W-1:0]     b_i,
    input  logic                  a_unsigned_i,
    input  logic                  b_unsigned_i,
    input  logic                  flush_i,
    output logic                  done_o,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  stall_o,
    output logic                  eng_start_o,
    output logic                  eng_abort_o,
    output logic                  eng_mul_or_div_o,
    output logic [DATA_W-1:0]     eng_a_o,
    output logic [DATA_W-1:0]     eng_b_o,
    output logic                  eng_a_unsigned_o,
    output logic                  eng_b_unsigned_o,
    input  logic                  eng_done_i,
    input  logic [2*DATA_W-1:0]   eng_result_i
);

    localparam int unsigned       RES_W   = 2 * DATA_W;
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               done_d;
    logic               start_d;
    logic               abort_d;
    logic               latch_en;
    logic               cache_wr;
    logic [RES_W-1:0]   result_d;

    // Last engine result and the operation tuple that produced it
    logic               cache_valid_q;
    logic               cache_mode_q;
    logic [DATA_W-1:0]  cache_a_q;
    logic [DATA_W-1:0]  cache_b_q;
    logic               cache_au_q;
    logic               cache_bu_q;
    logic [RES_W-1:0]   cache_res_q;

    logic               cache_hit_c;
    logic               div_zero_c;
    logic               div_ovf_c;
    logic [RES_W-1:0]   special_res_c;

    // Execute stage drops req_i while done_o is high, so DONE never stalls
    assign stall_o = req_i & ~done_o;

    // Hit only on the full tuple, so MULH->MUL and DIV->REM share one result
    assign cache_hit_c = CACHE_EN && cache_valid_q
                      && (cache_mode_q == mul_or_div_i)
                      && (cache_a_q == a_i) && (cache_b_q == b_i)
                      && (cache_au_q == a_unsigned_i)
                      && (cache_bu_q == b_unsigned_i);

    // RISC-V divide corner cases resolved locally
    assign div_zero_c = SPECIAL_EN && mul_or_div_i && (b_i == '0);
    assign div_ovf_c  = SPECIAL_EN && mul_or_div_i && !a_unsigned_i && !b_unsigned_i
                     && (a_i == MIN_NEG) && (b_i == '1);

    assign special_res_c = div_zero_c ? {{DATA_W{1'b1}}, a_i}
                                      : {MIN_NEG, {DATA_W{1'b0}}};

    // Next-state and next-output decode
    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        start_d  = 1'b0;
        abort_d  = 1'b0;
        latch_en = 1'b0;
        cache_wr = 1'b0;
        result_d = result_o;
        case (state_q)
            ST_IDLE: begin
                if (req_i && !flush_i) begin
                    latch_en = 1'b1;
                    if (cache_hit_c) begin
                        result_d = cache_res_q;
                        done_d   = 1'b1;
                        state_d  = ST_DONE;
                    end else if (div_zero_c || div_ovf_c) begin
                        result_d = special_res_c;
                        done_d   = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        start_d  = 1'b1;
                        state_d  = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                // Flush wins over a coincident completion
                if (flush_i) begin
                    abort_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (eng_done_i) begin
                    result_d = eng_result_i;
                    cache_wr = 1'b1;
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, registered outputs, operation latch and result cache
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= ST_IDLE;
            done_o           <= 1'b0;
            eng_start_o      <= 1'b0;
            eng_abort_o      <= 1'b0;
            result_o         <= '0;
            eng_mul_or_div_o <= 1'b0;
            eng_a_o          <= '0;
            eng_b_o          <= '0;
            eng_a_unsigned_o <= 1'b0;
            eng_b_unsigned_o <= 1'b0;
            cache_valid_q    <= 1'b0;
            cache_mode_q     <= 1'b0;
            cache_a_q        <= '0;
            cache_b_q        <= '0;
            cache_au_q       <= 1'b0;
            cache_bu_q       <= 1'b0;
            cache_res_q      <= '0;
        end else begin
            state_q     <= state_d;
            done_o      <= done_d;
            eng_start_o <= start_d;
            eng_abort_o <= abort_d;
            result_o    <= result_d;
            if (latch_en) begin
                eng_mul_or_div_o <= mul_or_div_i;
                eng_a_o          <= a_i;
                eng_b_o          <= b_i;
                eng_a_unsigned_o <= a_unsigned_i;
                eng_b_unsigned_o <= b_unsigned_i;
            end
            if (cache_wr) begin
                cache_valid_q <= 1'b1;
                cache_mode_q  <= eng_mul_or_div_o;
                cache_a_q     <= eng_a_o;
                cache_b_q     <= eng_b_o;
                cache_au_q    <= eng_a_unsigned_o;
                cache_bu_q    <= eng_b_unsigned_o;
                cache_res_q   <= eng_result_i;
            end
        end
    end

endmodule
